// File: rtl/min_sop_pkg.sv
// ============================================================================
// Module      : min_sop_pkg
// Description : Shared widths, default prime mask and minterm helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package min_sop_pkg;

    localparam int unsigned IN_W   = 4;
    localparam int unsigned MASK_W = 16;

    // Minterms 2, 3, 5, 7, 11, 13: the primes representable in four bits.
    localparam logic [MASK_W-1:0] PRIME_MASK = 16'h28AC;

    function automatic logic eval_minterm(
        input logic [MASK_W-1:0] mask,
        input logic [IN_W-1:0]   idx
    );
        return mask[idx];
    endfunction

endpackage : min_sop_pkg

`default_nettype wire

// File: rtl/min_sop_lut.sv
// ============================================================================
// Module      : min_sop_lut
// Description : Combinational 16:1 select of one minterm bit from the mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module min_sop_lut
    import min_sop_pkg::*;
(
    input  logic [MASK_W-1:0] mask,
    input  logic [IN_W-1:0]   idx,
    output logic              value
);

    always_comb begin
        value = eval_minterm(mask, idx);
    end

endmodule : min_sop_lut

`default_nettype wire

// File: rtl/min_sop.sv
// ============================================================================
// Module      : min_sop
// Description : Registered 4-input Boolean function held as a minterm mask.
//               Define MIN_SOP_CFG_EN to make the mask writable at runtime.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module min_sop
    import min_sop_pkg::*;
#(
    parameter logic [MASK_W-1:0] MINTERMS = PRIME_MASK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   a,
    input  logic              cfg_we,
    input  logic [MASK_W-1:0] cfg_mask,
    output logic              d
);

    logic [MASK_W-1:0] w_mask;
    logic              w_d_next;
    logic              r_d;

`ifdef MIN_SOP_CFG_EN
    logic [MASK_W-1:0] r_mask;

    // A write lands at the same edge that evaluates with the old mask, so the
    // new mask first affects the following evaluation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask <= MINTERMS;
        end else if (cfg_we) begin
            r_mask <= cfg_mask;
        end
    end

    assign w_mask = r_mask;
`else
    assign w_mask = MINTERMS;

    // Configuration ports are kept for a uniform interface but have no effect.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{cfg_we, cfg_mask};
`endif

    min_sop_lut u_lut (
        .mask  (w_mask),
        .idx   (a),
        .value (w_d_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d <= 1'b0;
        end else begin
            r_d <= w_d_next;
        end
    end

    assign d = r_d;

endmodule : min_sop

`default_nettype wire

// File: tb/tb_min_sop.sv
// ============================================================================
// Module      : tb_min_sop
// Description : Scoreboard bench for min_sop against a minterm-list model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_min_sop;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  a = 4'd0;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_mask = 16'h0000;
    logic        d;

    always #5 clk = ~clk;

    min_sop dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .cfg_we   (cfg_we),
        .cfg_mask (cfg_mask),
        .d        (d)
    );

    typedef struct {
        logic       exp;
        logic [3:0] a;
        int         step;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   step_no = 0;

    // Reference function: a truth table of 16 entries, set from a minterm list.
    bit   model_tt[16];
    int   primes[6] = '{2, 3, 5, 7, 11, 13};

    function automatic void model_reset_table();
        for (int i = 0; i < 16; i++) model_tt[i] = 1'b0;
        foreach (primes[k]) model_tt[primes[k]] = 1'b1;
    endfunction

    function automatic void model_load(input logic [15:0] m);
        for (int i = 0; i < 16; i++) model_tt[i] = m[i];
    endfunction

    task automatic step(input logic r, input logic [3:0] av,
                        input logic we, input logic [15:0] mv);
        exp_t e;
        @(negedge clk);
        rst_n    = r;
        a        = av;
        cfg_we   = we;
        cfg_mask = mv;
        e.exp  = r ? model_tt[av] : 1'b0;
        e.a    = av;
        e.step = step_no;
        step_no++;
        sb.push_back(e);
        if (!r) begin
            model_reset_table();
        end else if (we) begin
`ifdef MIN_SOP_CFG_EN
            model_load(mv);
`endif
        end
    endtask

    // Monitor: d is presented every cycle, one edge after its stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (d === e.exp) begin
                    passes++;
                end else begin
                    $display("FAIL step%0d a=%0d: d=%b expected %b",
                             e.step, e.a, d, e.exp);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        model_reset_table();

        // Reset held two edges with a=3, then release.
        step(1'b0, 4'd3, 1'b0, 16'h0);
        step(1'b0, 4'd3, 1'b0, 16'h0);
        step(1'b1, 4'd3, 1'b0, 16'h0);

        // Default sweep over every minterm index.
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b0, 16'h0);

        // Mid-run reset while d is high.
        step(1'b1, 4'd7, 1'b0, 16'h0);
        step(1'b0, 4'd7, 1'b0, 16'h0);
        step(1'b1, 4'd7, 1'b0, 16'h0);

        // Mask write, then probe both ends and a cleared prime.
        step(1'b1, 4'd0, 1'b1, 16'h8001);
        step(1'b1, 4'd0, 1'b0, 16'h0);
        step(1'b1, 4'd15, 1'b0, 16'h0);
        step(1'b1, 4'd2, 1'b0, 16'h0);

        // Write coinciding with evaluation uses the old mask.
        step(1'b0, 4'd2, 1'b0, 16'h0);
        step(1'b1, 4'd2, 1'b1, 16'h0000);
        step(1'b1, 4'd2, 1'b0, 16'h0);
        step(1'b0, 4'd2, 1'b1, 16'h0000);
        step(1'b1, 4'd2, 1'b0, 16'h0);

        // Write then probe a=13 (ignored without the configuration feature).
        step(1'b1, 4'd13, 1'b1, 16'h0000);
        step(1'b1, 4'd13, 1'b0, 16'h0);

        // Randomized traffic with occasional writes and resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(19) != 0), 4'($urandom_range(15)),
                 ($urandom_range(7) == 0), 16'($urandom));
        end

        @(negedge clk);
        rst_n  = 1'b1;
        cfg_we = 1'b0;
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 5) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        if (checks < 12) begin
            checks++;
            $display("FAIL check_count: %0d made, expected at least 12", checks - 1);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_min_sop

`default_nettype wire
